pdm_window_tx: RTL and testbench

//  Pulse-density transmitter, the sending end of the diff_sampler link. Takes SAMPLE_W-bit

---
 rtl/pdm_window_tx.sv | 159 +++++++++++++++
 tb/tb_pdm_window_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_window_tx.sv
// Pulse-density transmitter: pops one high-count per WINDOW-cycle window from a small FIFO
// and spreads that many '1' cycles across the window with a first-order error accumulator.
module pdm_window_tx #(
  parameter int WINDOW     = 128,
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic                pdm_out,
  output logic                window_start,
  output logic                busy,
  output logic                underrun,
  output logic                clamped,
  output logic [15:0]         underrun_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam int CNT_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int S_W    = $clog2(WINDOW + 1);
  localparam int ACC_W  = $clog2(2 * WINDOW) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   win_cnt, win_cnt_next;

  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [FILL_W-1:0]   fill;
  logic                rdy_q;
  logic                fifo_empty;
  logic                push;
  logic                pop;

  logic                boundary;
  logic [SAMPLE_W-1:0] head_raw;
  logic                head_clip;
  logic [S_W-1:0]      samp;
  logic [S_W-1:0]      s_cur;
  logic [ACC_W-1:0]    acc_p1;
  logic [ACC_W-1:0]    a_p0;
  logic                bit_p0;

  function automatic logic [S_W-1:0] clamp_sample(input logic [SAMPLE_W-1:0] v);
    if (v > SAMPLE_W'(WINDOW)) return S_W'(WINDOW);
    return S_W'(v);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  // s_ready is held low until the first clock after reset release
  assign fifo_empty = (fill == '0);
  assign s_ready    = rdy_q && (fill < FILL_W'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;
  assign boundary   = (state == RUN) && (win_cnt == '0);
  assign pop        = boundary && !fifo_empty;
  assign busy       = (state == RUN);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      rdy_q  <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      win_cnt <= '0;
    end else begin
      state   <= state_next;
      win_cnt <= win_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    win_cnt_next = win_cnt;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next   = RUN;
          win_cnt_next = '0;
        end
      end
      RUN: begin
        if (win_cnt == CNT_W'(WINDOW - 1)) begin
          win_cnt_next = '0;
          if (!enable) state_next = IDLE;
        end else begin
          win_cnt_next = win_cnt + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // p0: sample select and accumulate; the accumulator restarts at every boundary
  assign head_raw  = mem[rd_ptr];
  assign head_clip = (head_raw > SAMPLE_W'(WINDOW));

  always_comb begin
    s_cur = samp;
    if (boundary) s_cur = fifo_empty ? '0 : clamp_sample(head_raw);
  end

  assign a_p0   = ((win_cnt == '0) ? '0 : acc_p1) + ACC_W'(s_cur);
  assign bit_p0 = (a_p0 >= ACC_W'(WINDOW));

  // p1: registered stream, window markers and accumulator residue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp           <= '0;
      acc_p1         <= '0;
      pdm_out        <= 1'b0;
      window_start   <= 1'b0;
      underrun       <= 1'b0;
      clamped        <= 1'b0;
      underrun_count <= '0;
    end else begin
      window_start <= boundary;
      underrun     <= boundary && fifo_empty;
      clamped      <= pop && head_clip;
      if (boundary) samp <= s_cur;
      if (boundary && fifo_empty) underrun_count <= sat_inc16(underrun_count);
      if (state == RUN) begin
        pdm_out <= bit_p0;
        acc_p1  <= bit_p0 ? (a_p0 - ACC_W'(WINDOW)) : a_p0;
      end else begin
        pdm_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_window_tx.sv
// Bench for pdm_window_tx: queue-and-formula reference model checked every cycle, plus
// per-window tallies compared against hand-computed values.
`timescale 1ns/1ps
module tb_pdm_window_tx;

  localparam int W = 128;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, pdm_out, window_start, busy, underrun, clamped;
  logic [15:0] underrun_count;

  always #5 clk = ~clk;

  pdm_window_tx #(.WINDOW(W), .SAMPLE_W(16), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .pdm_out(pdm_out), .window_start(window_start), .busy(busy),
    .underrun(underrun), .clamped(clamped), .underrun_count(underrun_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", name, $time);
  endtask

  // Number of ones in bits 0..k is floor((k+1)*S/W), so bit k is the step of that staircase
  function automatic int bit_of(input int s, input int k);
    return ((k + 1) * s) / W - (k * s) / W;
  endfunction

  bit m_run, m_rdy, e_pdm, e_ws, e_und, e_clp;
  int m_k, m_S, m_uc;
  int q[$];

  always @(posedge clk or negedge rst_n) begin : model
    int  v;
    bit  pu;
    if (!rst_n) begin
      m_run = 0; m_rdy = 0; m_k = 0; m_S = 0; m_uc = 0;
      e_pdm = 0; e_ws = 0; e_und = 0; e_clp = 0;
      q.delete();
    end else begin
      pu = s_valid && m_rdy && (q.size() < D);
      e_pdm = 0; e_ws = 0; e_und = 0; e_clp = 0;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_k = 0; end
      end else begin
        if (m_k == 0) begin
          e_ws = 1;
          if (q.size() > 0) begin
            v = q.pop_front();
            e_clp = (v > W);
            m_S = (v > W) ? W : v;
          end else begin
            m_S = 0;
            e_und = 1;
            if (m_uc < 65535) m_uc++;
          end
        end
        e_pdm = (bit_of(m_S, m_k) != 0);
        if (m_k == W - 1) begin
          if (enable) m_k = 0; else m_run = 0;
        end else m_k++;
      end
      if (pu) q.push_back(int'(s_data));
      m_rdy = 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("pdm_out", int'(pdm_out), int'(e_pdm));
      check("window_start", int'(window_start), int'(e_ws));
      check("busy", int'(busy), int'(m_run));
      check("underrun", int'(underrun), int'(e_und));
      check("clamped", int'(clamped), int'(e_clp));
      check("underrun_count", int'(underrun_count), m_uc);
      check("s_ready", int'(s_ready), int'(m_rdy && (q.size() < D)));
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  bit mon_act;
  int cur_len, cur_ones, cur_first;
  int ws_total = 0, clamp_seen = 0, under_seen = 0;
  int rec_ones[$], rec_first[$], ws_cyc[$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_act = 0;
      cur_len = 0;
    end else begin
      if (window_start) begin
        ws_total++;
        ws_cyc.push_back(cyc);
        mon_act = 1; cur_len = 0; cur_ones = 0; cur_first = -1;
      end
      if (clamped) clamp_seen++;
      if (underrun) under_seen++;
      if (mon_act) begin
        if (pdm_out) begin
          cur_ones++;
          if (cur_first < 0) cur_first = cur_len;
        end
        cur_len++;
        if (cur_len == W) begin
          rec_ones.push_back(cur_ones);
          rec_first.push_back(cur_first);
          mon_act = 0;
        end
      end
    end
  end

  task automatic clear_recs();
    rec_ones.delete(); rec_first.delete(); ws_cyc.delete();
    clamp_seen = 0; under_seen = 0;
  endtask

  task automatic push(input int v);
    int n;
    n = 0;
    @(negedge clk);
    s_data = 16'(v);
    s_valid = 1'b1;
    while (!s_ready && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) timeout("push");
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_ws();
    int s, t;
    s = ws_total; t = 0;
    while (ws_total == s && t < 50) begin @(negedge clk); t++; end
    if (ws_total == s) timeout("wait_window_start");
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin @(negedge clk); t++; end
    if (busy) timeout("wait_idle");
    repeat (3) @(negedge clk);
  endtask

  task automatic run_windows(input int n);
    int s, t;
    @(negedge clk);
    enable = 1'b1;
    s = ws_total; t = 0;
    while ((ws_total - s) < n && t < n * 140 + 20) begin @(negedge clk); t++; end
    if ((ws_total - s) < n) timeout("run_windows");
    enable = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sv[4];
    repeat (3) @(negedge clk);
    check("rst_pdm_out", int'(pdm_out), 0);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_underrun_count", int'(underrun_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_after_rst", int'(s_ready), 1);

    // Half density: alternating 0,1
    clear_recs();
    push(64);
    run_windows(1);
    check("t1_windows", rec_ones.size(), 1);
    if (rec_ones.size() == 1) begin
      check("t1_ones", rec_ones[0], 64);
      check("t1_first_one", rec_first[0], 1);
    end

    // Extremes back to back
    clear_recs();
    push(0); push(1); push(128);
    run_windows(3);
    check("t2_windows", rec_ones.size(), 3);
    if (rec_ones.size() == 3) begin
      check("t2_ones_a", rec_ones[0], 0);
      check("t2_ones_b", rec_ones[1], 1);
      check("t2_ones_c", rec_ones[2], 128);
      check("t2_first_a", rec_first[0], -1);
      check("t2_first_b", rec_first[1], 127);
      check("t2_first_c", rec_first[2], 0);
      check("t2_gap_ab", ws_cyc[1] - ws_cyc[0], 128);
      check("t2_gap_bc", ws_cyc[2] - ws_cyc[1], 128);
    end

    // Over-range sample
    clear_recs();
    push(200);
    run_windows(1);
    check("t3_windows", rec_ones.size(), 1);
    if (rec_ones.size() == 1) check("t3_ones", rec_ones[0], 128);
    check("t3_clamped_pulses", clamp_seen, 1);
    check("t3_underrun_pulses", under_seen, 0);

    // Empty FIFO
    clear_recs();
    run_windows(1);
    check("t4_windows", rec_ones.size(), 1);
    if (rec_ones.size() == 1) check("t4_ones", rec_ones[0], 0);
    check("t4_underrun_pulses", under_seen, 1);
    check("t4_count_1", int'(underrun_count), 1);
    run_windows(2);
    check("t4_count_3", int'(underrun_count), 3);

    // Fill the FIFO, then drain in order
    clear_recs();
    push(10); push(20); push(30); push(40);
    check("t5_full_s_ready", int'(s_ready), 0);
    run_windows(4);
    check("t5_windows", rec_ones.size(), 4);
    if (rec_ones.size() == 4) begin
      check("t5_ones_0", rec_ones[0], 10);
      check("t5_ones_1", rec_ones[1], 20);
      check("t5_ones_2", rec_ones[2], 30);
      check("t5_ones_3", rec_ones[3], 40);
      check("t5_first_10", rec_first[0], 12);
    end

    // Reset in the middle of a window
    clear_recs();
    push(100); push(77);
    @(negedge clk);
    enable = 1'b1;
    wait_ws();
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_pdm_out", int'(pdm_out), 0);
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_s_ready", int'(s_ready), 0);
    enable = 1'b0;
    @(negedge clk);
    check("t6_rst_s_ready_hold", int'(s_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_s_ready_back", int'(s_ready), 1);
    check("t6_count_cleared", int'(underrun_count), 0);
    clear_recs();
    run_windows(1);
    check("t6_windows_after_rst", rec_ones.size(), 1);
    if (rec_ones.size() == 1) check("t6_fifo_lost", rec_ones[0], 0);

    // Disable partway through a window
    clear_recs();
    push(50); push(90);
    @(negedge clk);
    enable = 1'b1;
    wait_ws();
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_idle();
    check("t6b_windows", rec_ones.size(), 1);
    if (rec_ones.size() == 1) check("t6b_ones", rec_ones[0], 50);
    clear_recs();
    run_windows(1);
    check("t6b_next_windows", rec_ones.size(), 1);
    if (rec_ones.size() == 1) check("t6b_next_ones", rec_ones[0], 90);

    // Window-aligned recovery of random densities
    for (int r = 0; r < 2; r++) begin
      clear_recs();
      for (int i = 0; i < 4; i++) begin
        sv[i] = int'($urandom_range(0, 128));
        push(sv[i]);
      end
      run_windows(4);
      check("t7_windows", rec_ones.size(), 4);
      if (rec_ones.size() == 4)
        for (int i = 0; i < 4; i++) check("t7_recovered", rec_ones[i], sv[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
